layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
Sits between two neuron layers. It collects the parallel per-neuron results of one layer (NN words, each with its own valid pulse) and replays them as the serial x_in/x_valid word stream the next layer consumes, word 0 first, one word per clock. A capture buffer and a shift buffer let the next frame be collected while the current one is still being sent.

Parameters:
NN, 30, number of neurons (words) per frame
dataWidth, 16, width of each neuron output word

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
o_valid  input  NN  per-neuron one-cycle result-valid pulses; bit i qualifies word i
x_out  input  NN*dataWidth  parallel neuron results; word i = x_out[i*dataWidth +: dataWidth]
x_in  output  dataWidth  serial word to next layer (registered)
x_valid  output  1  qualifies x_in (registered)
busy  output  1  high while state SEND
frame_done  output  1  one-cycle pulse coincident with word NN-1 on x_in
overrun  output  1  sticky error flag, cleared only by rst

Behaviour:
- Reset (rst=1 at an edge): state IDLE, capture mask=0, count=0. x_in=0, x_valid=0, busy=0, frame_done=0, overrun=0. Reset mid-frame aborts the frame; any partially captured words are discarded.
- Capture buffer: NN words plus NN-bit mask, active in every state.
  - o_valid[i]=1 and mask[i]=0: latch word i, set mask[i].
  - o_valid[i]=1 and mask[i]=1: keep the old word, set overrun.
  - Bits are independent; any subset may pulse in the same cycle.
- mask_full = &mask (combinational on the registered mask).
- Load event: mask_full and (state IDLE, or state SEND with count==NN). On a load event:
  - Copy the capture buffer to the shift buffer.
  - Clear the mask. An o_valid bit arriving in the same cycle is recorded into the cleared mask with its word; this is not an overrun.
  - Drive x_in<=word0 and x_valid<=1; set count<=1; state<=SEND.
  - If NN==1, frame_done<=1 on this load.
- SEND, count<NN: x_in<=shift[count], x_valid<=1, count<=count+1. frame_done<=1 when count==NN-1, else 0.
- SEND, count==NN:
  - If mask_full: load event (back-to-back frames, no idle gap).
  - Else: x_valid<=0, x_in holds its last value, frame_done<=0, state<=IDLE.
- busy is high when state is SEND.
- Latency: the last o_valid bit of a frame is sampled at edge t, so the mask is full during cycle t+1. x_valid rises after edge t+1, i.e. the first word is visible during cycle t+2.
- Output rate:
  - Exactly NN consecutive x_valid cycles per frame, no bubbles.
  - Back-to-back frames give 2*NN contiguous valid cycles.
- Counter width: $clog2(NN+1). It never exceeds NN.

Test Plan:
1. NN=4, dataWidth=16. Pulse all o_valid=4'b1111 in one cycle with words 0x0001..0x0004.
   - Two cycles later, x_valid is high for exactly 4 cycles carrying 0x0001, 0x0002, 0x0003, 0x0004.
   - frame_done pulses on 0x0004; busy is high for those 4 cycles; overrun=0.
2. Staggered capture: pulse bits 0, 2, 1, 3 on separate cycles (words 0xA0, 0xA2, 0xA1, 0xA3).
   - Output order is 0xA0, 0xA1, 0xA2, 0xA3.
   - No output before bit 3 is captured.
3. Back-to-back: while frame 1 is sending, capture a full frame 2 (0xB0..0xB3).
   - x_valid stays high for 8 contiguous cycles, frame 1 words then 0xB0..0xB3.
   - Two frame_done pulses, 4 cycles apart.
4. Overrun: pulse bit 1 twice (0x11 then 0x22) before the frame completes.
   - overrun=1 and stays 1 until rst.
   - The sent word 1 is 0x11.
5. Reset mid-operation: assert rst after the second output word.
   - Next cycle x_valid=0, busy=0, overrun=0.
   - A fresh full frame afterwards is sent intact, starting with word 0.
6. Load-cycle collision: o_valid[0] pulses in the same cycle as a load.
   - No overrun; the new word 0 is held for the next frame, and mask bit 0 reads 1 after the load.

Source files
------------

// File: rtl/layer_output_serializer.sv
// Collects one layer's parallel neuron results and replays them as a
// serial word stream; a capture/shift pair lets frames overlap.
module layer_output_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           o_valid,
  input  logic [NN*dataWidth-1:0] x_out,
  output logic [dataWidth-1:0]    x_in,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int CW = $clog2(NN + 1);
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q;
  logic [NN-1:0][dataWidth-1:0]   cap_q, cap_d;
  logic [NN-1:0][dataWidth-1:0]   shift_q;
  logic [NN-1:0]                  mask_q, mask_d, mask_base;
  logic [CW-1:0]                  cnt_q;
  logic [dataWidth-1:0]           x_in_q;
  logic                           x_valid_q;
  logic                           done_q;
  logic                           ovr_q, ovr_d;
  logic                           mask_full, last, load;
  logic [IW-1:0]                  idx;

  assign mask_full = &mask_q;
  assign last      = (cnt_q == CW'(NN));
  assign load      = mask_full && ((state_q == IDLE) || last);
  assign idx       = cnt_q[IW-1:0];

  // A load clears the mask first, so same-cycle pulses start the next frame.
  assign mask_base = load ? '0 : mask_q;

  always_comb begin
    cap_d  = cap_q;
    mask_d = mask_base;
    ovr_d  = ovr_q;
    for (int i = 0; i < NN; i++) begin
      if (o_valid[i]) begin
        if (mask_base[i]) begin
          ovr_d = 1'b1;
        end else begin
          cap_d[i]  = x_out[i*dataWidth +: dataWidth];
          mask_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    cap_q <= cap_d;
    if (load) shift_q <= cap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      cnt_q     <= '0;
      x_in_q    <= '0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      mask_q <= mask_d;
      ovr_q  <= ovr_d;
      if (load) begin
        state_q   <= SEND;
        cnt_q     <= CW'(1);
        x_in_q    <= cap_q[0];
        x_valid_q <= 1'b1;
        done_q    <= (NN == 1);
      end else if (state_q == SEND && !last) begin
        cnt_q     <= cnt_q + 1'b1;
        x_in_q    <= shift_q[idx];
        x_valid_q <= 1'b1;
        done_q    <= (cnt_q == CW'(NN - 1));
      end else begin
        state_q   <= IDLE;
        x_valid_q <= 1'b0;
        done_q    <= 1'b0;
      end
    end
  end

  assign x_in       = x_in_q;
  assign x_valid    = x_valid_q;
  assign busy       = (state_q == SEND);
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: directed scenarios plus random
// traffic compared cycle by cycle with a frame-level reference model.
module tb_layer_output_serializer;

  localparam int NN = 4;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NN-1:0]   o_valid;
  logic [NN*W-1:0] x_out;
  logic [W-1:0]    x_in;
  logic            x_valid, busy, frame_done, overrun;

  int tests = 0;
  int fails = 0;

  layer_output_serializer #(.NN(NN), .dataWidth(W)) dut (
    .clk(clk), .rst(rst), .o_valid(o_valid), .x_out(x_out),
    .x_in(x_in), .x_valid(x_valid), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference: words waiting to be sent, words captured for the next frame.
  int m_cap  [NN];
  bit m_have [NN];
  int m_frame[NN];
  bit m_send;
  int m_sent;
  int m_xin;
  bit m_xv, m_done, m_ovr;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit all_have();
    for (int i = 0; i < NN; i++) if (!m_have[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit [NN-1:0] v,
                            input bit [NN*W-1:0] d);
    bit start;
    if (r) begin
      m_send = 0; m_sent = 0; m_xin = 0;
      m_xv = 0; m_done = 0; m_ovr = 0;
      for (int i = 0; i < NN; i++) m_have[i] = 0;
      return;
    end
    start = all_have() && (!m_send || m_sent == NN);
    if (start) begin
      for (int i = 0; i < NN; i++) begin
        m_frame[i] = m_cap[i];
        m_have[i]  = 0;
      end
      m_send = 1; m_sent = 1;
      m_xin = m_frame[0]; m_xv = 1; m_done = (NN == 1);
    end else if (m_send && m_sent < NN) begin
      m_xin = m_frame[m_sent];
      m_done = (m_sent == NN - 1);
      m_sent++; m_xv = 1;
    end else begin
      m_send = 0; m_xv = 0; m_done = 0;
    end
    for (int i = 0; i < NN; i++) begin
      if (v[i]) begin
        if (m_have[i]) m_ovr = 1;
        else begin
          m_have[i] = 1;
          m_cap[i]  = int'(d[i*W +: W]);
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit [NN-1:0] v,
                     input bit [NN*W-1:0] d);
    rst = r; o_valid = v; x_out = d;
    @(posedge clk);
    model_step(r, v, d);
    @(negedge clk);
    check("x_valid",    int'(x_valid),    int'(m_xv));
    check("x_in",       int'(x_in),       m_xin);
    check("busy",       int'(busy),       int'(m_send));
    check("frame_done", int'(frame_done), int'(m_done));
    check("overrun",    int'(overrun),    int'(m_ovr));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, '0, $urandom);
  endtask

  function automatic bit [NN*W-1:0] word_at(input int i, input int w);
    bit [NN*W-1:0] d;
    d = '0;
    d[i*W +: W] = W'(w);
    return d;
  endfunction

  function automatic bit [NN*W-1:0] frame(input int base);
    bit [NN*W-1:0] d;
    for (int i = 0; i < NN; i++) d[i*W +: W] = W'(base + i);
    return d;
  endfunction

  initial begin
    rst = 1; o_valid = '0; x_out = '0;
    @(negedge clk);
    cyc(1, '0, '0);
    cyc(1, '0, '0);
    check("reset_xv", int'(x_valid), 0);
    check("reset_ovr", int'(overrun), 0);

    cyc(0, 4'b1111, frame(16'h0001));
    check("latency_t1", int'(x_valid), 0);
    cyc(0, '0, '0);
    check("first_word", int'(x_in), 16'h0001);
    idle(6);

    cyc(0, 4'b0001, word_at(0, 16'hA0));
    cyc(0, 4'b0100, word_at(2, 16'hA2));
    cyc(0, 4'b0010, word_at(1, 16'hA1));
    check("no_early_out", int'(x_valid), 0);
    cyc(0, 4'b1000, word_at(3, 16'hA3));
    idle(7);

    cyc(0, 4'b1111, frame(16'hC0));
    cyc(0, 4'b0011, frame(16'hB0));
    cyc(0, 4'b0100, frame(16'hB0));
    cyc(0, 4'b1000, frame(16'hB0));
    idle(10);

    cyc(0, 4'b0010, word_at(1, 16'h11));
    cyc(0, 4'b0010, word_at(1, 16'h22));
    check("overrun_set", int'(overrun), 1);
    cyc(0, 4'b1101, frame(16'h10));
    idle(7);
    check("overrun_sticky", int'(overrun), 1);

    cyc(0, 4'b1111, frame(16'h50));
    idle(3);
    cyc(1, '0, '0);
    check("rst_mid_xv", int'(x_valid), 0);
    check("rst_mid_ovr", int'(overrun), 0);
    cyc(0, 4'b1111, frame(16'h60));
    idle(7);

    cyc(0, 4'b1111, frame(16'h70));
    cyc(0, 4'b0001, word_at(0, 16'h99));
    check("collide_ovr", int'(overrun), 0);
    cyc(0, 4'b1110, frame(16'h80));
    idle(12);
    check("collide_ovr2", int'(overrun), 0);

    for (int k = 0; k < 600; k++) begin
      bit [NN-1:0] v;
      bit [NN*W-1:0] d;
      for (int i = 0; i < NN; i++) begin
        v[i] = ($urandom_range(0, 4) == 0);
        d[i*W +: W] = W'($urandom);
      end
      cyc(($urandom_range(0, 249) == 0), v, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
